// File: rtl/sync_pkg.sv
// sync_pkg: shared types and constants for the multi-channel edge synchroniser.
//   edge_mode_e      per-channel output mode (level / rise / fall / both)
//   MIN/MAX_SYNC_STAGES  legal synchroniser depth range
package sync_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'b00,
        MODE_RISE  = 2'b01,
        MODE_FALL  = 2'b10,
        MODE_BOTH  = 2'b11
    } edge_mode_e;

    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MAX_SYNC_STAGES = 4;

endpackage

// File: rtl/sync_edge_chan.sv
// sync_edge_chan: one channel of the edge synchroniser.
// Flop-chain synchroniser, optional stability filter, edge detector,
// registered event output, sticky flag and saturating event counter.
// Ports:
//   clk_fast  in   fast-domain clock
//   rst       in   synchronous active-high reset
//   din_i     in   asynchronous / slow-domain input bit
//   mode_i    in   output mode (edge_mode_e encoding)
//   clr_i     in   clear sticky flag and counter
//   evt_o     out  registered pulse, or filtered level in MODE_LEVEL
//   sticky_o  out  sticky event flag
//   cnt_o     out  saturating event count
module sync_edge_chan
    import sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 0,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk_fast,
    input  logic             rst,
    input  logic             din_i,
    input  logic [1:0]       mode_i,
    input  logic             clr_i,
    output logic             evt_o,
    output logic             sticky_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt;
    logic                   fd_q;
    logic                   evt_q, evt_d;
    logic                   sticky_q, sticky_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rise, fall, hit;

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
        end
    end

    generate
        if (FILTER_CYCLES == 0) begin : g_bypass
            assign filt = sync_q[SYNC_STAGES-1];
        end else begin : g_filter
            localparam int unsigned FC_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
            logic [FC_W-1:0] fc_q;
            logic            filt_q;

            // A new synchronised value is accepted only after it has differed
            // from the held value for FILTER_CYCLES consecutive cycles.
            always_ff @(posedge clk_fast) begin
                if (rst) begin
                    fc_q   <= '0;
                    filt_q <= 1'b0;
                end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
                    fc_q <= '0;
                end else if (fc_q == FC_W'(FILTER_CYCLES - 1)) begin
                    filt_q <= sync_q[SYNC_STAGES-1];
                    fc_q   <= '0;
                end else begin
                    fc_q <= fc_q + FC_W'(1);
                end
            end

            assign filt = filt_q;
        end
    endgenerate

    // Edges come only from filt/fd_q, so a mode change alone never pulses.
    always_comb begin
        rise  = filt & ~fd_q;
        fall  = ~filt & fd_q;
        evt_d = 1'b0;
        hit   = 1'b0;
        case (edge_mode_e'(mode_i))
            MODE_LEVEL: evt_d = filt;
            MODE_RISE:  begin evt_d = rise;        hit = rise;        end
            MODE_FALL:  begin evt_d = fall;        hit = fall;        end
            MODE_BOTH:  begin evt_d = rise | fall; hit = rise | fall; end
            default:    evt_d = 1'b0;
        endcase

        // A coincident event beats the clear.
        sticky_d = sticky_q;
        if (hit) begin
            sticky_d = 1'b1;
        end else if (clr_i) begin
            sticky_d = 1'b0;
        end

        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CNT_W'(hit);
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            fd_q     <= 1'b0;
            evt_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            fd_q     <= filt;
            evt_q    <= evt_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign evt_o    = evt_q;
    assign sticky_o = sticky_q;
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/multi_ch_edge_sync.sv
// multi_ch_edge_sync: NUM_CH independent slow-to-fast edge synchronisers.
// Ports:
//   clk_fast  in   sole clock
//   rst       in   synchronous active-high reset
//   din_i     in   [NUM_CH]        asynchronous / slow-domain inputs
//   mode_i    in   [2*NUM_CH]      per-channel mode, channel c in [2c+1:2c]
//   clr_i     in   [NUM_CH]        per-channel clear of sticky flag and counter
//   evt_o     out  [NUM_CH]        registered pulse, or level in mode 00
//   sticky_o  out  [NUM_CH]        sticky event flags
//   cnt_o     out  [NUM_CH*CNT_W]  saturating counts, channel c at [c*CNT_W +: CNT_W]
module multi_ch_edge_sync
    import sync_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 0,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                    clk_fast,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       din_i,
    input  logic [2*NUM_CH-1:0]     mode_i,
    input  logic [NUM_CH-1:0]       clr_i,
    output logic [NUM_CH-1:0]       evt_o,
    output logic [NUM_CH-1:0]       sticky_o,
    output logic [NUM_CH*CNT_W-1:0] cnt_o
);

    generate
        if (NUM_CH < 1) begin : g_bad_num_ch
            $error("multi_ch_edge_sync: NUM_CH must be >= 1");
        end
        if ((SYNC_STAGES < MIN_SYNC_STAGES) || (SYNC_STAGES > MAX_SYNC_STAGES)) begin : g_bad_sync
            $error("multi_ch_edge_sync: SYNC_STAGES must be in 2..4");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("multi_ch_edge_sync: CNT_W must be >= 1");
        end
    endgenerate

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        sync_edge_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clk_fast(clk_fast),
            .rst     (rst),
            .din_i   (din_i[c]),
            .mode_i  (mode_i[2*c +: 2]),
            .clr_i   (clr_i[c]),
            .evt_o   (evt_o[c]),
            .sticky_o(sticky_o[c]),
            .cnt_o   (cnt_o[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_multi_ch_edge_sync.sv
// tb_multi_ch_edge_sync: directed checks on three configurations
//   A: defaults (bypass filter, 8-bit counters)
//   B: FILTER_CYCLES=3
//   C: CNT_W=3
module tb_multi_ch_edge_sync;

    logic clk_fast = 1'b0;
    always #5 clk_fast = ~clk_fast;

    logic        rst_a, rst_b, rst_c;
    logic [3:0]  din_a, din_b, din_c;
    logic [7:0]  mode_a, mode_b, mode_c;
    logic [3:0]  clr_a, clr_b, clr_c;
    logic [3:0]  evt_a, evt_b, evt_c;
    logic [3:0]  sticky_a, sticky_b, sticky_c;
    logic [31:0] cnt_a, cnt_b;
    logic [11:0] cnt_c;

    multi_ch_edge_sync #(.NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(0), .CNT_W(8)) u_dut_a (
        .clk_fast(clk_fast), .rst(rst_a), .din_i(din_a), .mode_i(mode_a), .clr_i(clr_a),
        .evt_o(evt_a), .sticky_o(sticky_a), .cnt_o(cnt_a)
    );

    multi_ch_edge_sync #(.NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .CNT_W(8)) u_dut_b (
        .clk_fast(clk_fast), .rst(rst_b), .din_i(din_b), .mode_i(mode_b), .clr_i(clr_b),
        .evt_o(evt_b), .sticky_o(sticky_b), .cnt_o(cnt_b)
    );

    multi_ch_edge_sync #(.NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(0), .CNT_W(3)) u_dut_c (
        .clk_fast(clk_fast), .rst(rst_c), .din_i(din_c), .mode_i(mode_c), .clr_i(clr_c),
        .evt_o(evt_c), .sticky_o(sticky_c), .cnt_o(cnt_c)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    // Per-mode expectations for channel 0: 10 cycles high then low.
    int unsigned exp_hi[4]     = '{10, 1, 1, 2};
    int unsigned exp_pulses[4] = '{1, 1, 1, 2};
    int          exp_first[4]  = '{2, 2, 12, 2};
    int unsigned exp_cnt[4]    = '{0, 1, 1, 2};
    int unsigned exp_stk[4]    = '{0, 1, 1, 1};

    int unsigned highs, pulses;
    int          first;
    logic        prev;
    logic [3:0]  other_evt;
    logic [7:0]  pat;

    // Reference model state for the random run on DUT A.
    logic [3:0]  h0, h1, h2, h3;
    logic [3:0]  m_evt, m_sticky, m_hit;
    logic [7:0]  m_cnt [4];
    logic [7:0]  mode_now;
    logic [3:0]  clr_now;

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; din_a = 4'hF; mode_a = 8'h55; clr_a = 4'h0;
        rst_b = 1'b1; din_b = 4'h0; mode_b = 8'h55; clr_b = 4'h0;
        rst_c = 1'b1; din_c = 4'h0; mode_c = 8'h01; clr_c = 4'h0;

        // ---------------- Reset behaviour (A) ----------------
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_evt", 32'(evt_a), 32'h0);
            check("rst_sticky", 32'(sticky_a), 32'h0);
            check("rst_cnt", cnt_a, 32'h0);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_rel_evt", 32'(evt_a), (i == 2) ? 32'hF : 32'h0);
        end
        check("rst_rel_sticky", 32'(sticky_a), 32'hF);
        check("rst_rel_cnt", cnt_a, 32'h01010101);

        // ---------------- Modes on channel 0 (A) ----------------
        din_a  = 4'h0;
        mode_a = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        for (int m = 0; m < 4; m++) begin
            mode_a[1:0] = 2'(m);
            clr_a = 4'hF;
            tick();
            clr_a = 4'h0;
            highs = 0; pulses = 0; first = -1; prev = 1'b0; other_evt = 4'h0;
            for (int i = 0; i < 25; i++) begin
                din_a[0] = (i < 10);
                tick();
                if (evt_a[0]) begin
                    highs++;
                    if (!prev) pulses++;
                    if (first < 0) first = i;
                end
                prev = evt_a[0];
                other_evt = other_evt | {evt_a[3:1], 1'b0};
            end
            check($sformatf("mode%0d_high_cycles", m), highs, exp_hi[m]);
            check($sformatf("mode%0d_pulses", m), pulses, exp_pulses[m]);
            check($sformatf("mode%0d_first", m), 32'(first), 32'(exp_first[m]));
            check($sformatf("mode%0d_cnt0", m), 32'(cnt_a[7:0]), exp_cnt[m]);
            check($sformatf("mode%0d_sticky0", m), 32'(sticky_a[0]), exp_stk[m]);
            check($sformatf("mode%0d_other_ch", m), 32'(other_evt), 32'h0);
        end

        // Mode 11 with a one-cycle synchronised pulse: two adjacent pulses.
        mode_a[1:0] = 2'b11;
        clr_a = 4'hF;
        tick();
        clr_a = 4'h0;
        pat = 8'h00;
        for (int i = 0; i < 8; i++) begin
            din_a[0] = (i == 0);
            tick();
            pat[i] = evt_a[0];
        end
        check("both_b2b_pattern", 32'(pat), 32'h0C);
        check("both_b2b_cnt0", 32'(cnt_a[7:0]), 32'd2);

        // ---------------- Mid-operation reset (A) ----------------
        mode_a[1:0] = 2'b01;
        clr_a = 4'hF;
        tick();
        clr_a = 4'h0;
        din_a[0] = 1'b1;
        tick();
        din_a[0] = 1'b0;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (evt_a[0]) highs++;
        end
        check("midrst_no_pulse", highs, 0);
        check("midrst_cnt0", 32'(cnt_a[7:0]), 32'h0);
        check("midrst_sticky0", 32'(sticky_a[0]), 32'h0);

        // ---------------- Filter (B) ----------------
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            din_b[0] = (i < 2);
            tick();
            if (evt_b[0]) highs++;
        end
        check("filt_glitch_evt", highs, 0);
        check("filt_glitch_cnt", 32'(cnt_b[7:0]), 32'h0);
        check("filt_glitch_sticky", 32'(sticky_b[0]), 32'h0);
        for (int len = 5; len >= 3; len -= 2) begin
            highs = 0; first = -1;
            for (int i = 0; i < 16; i++) begin
                din_b[0] = (i < len);
                tick();
                if (evt_b[0]) begin
                    highs++;
                    if (first < 0) first = i;
                end
            end
            check($sformatf("filt_len%0d_pulses", len), highs, 1);
            check($sformatf("filt_len%0d_first", len), 32'(first), 32'd5);
        end
        check("filt_cnt", 32'(cnt_b[7:0]), 32'd2);

        // ---------------- Saturation and clear (C) ----------------
        pulses = 0;
        for (int e = 0; e < 10; e++) begin
            for (int i = 0; i < 6; i++) begin
                din_c[0] = (i < 3);
                tick();
                if (evt_c[0]) pulses++;
            end
        end
        check("sat_pulses", pulses, 10);
        check("sat_cnt0", 32'(cnt_c[2:0]), 32'd7);
        check("sat_sticky0", 32'(sticky_c[0]), 32'h1);
        check("sat_other_cnt", 32'(cnt_c[11:3]), 32'h0);
        din_c[0] = 1'b1;
        tick();
        tick();
        clr_c[0] = 1'b1;
        tick();
        clr_c[0] = 1'b0;
        check("clr_evt_evt0", 32'(evt_c[0]), 32'h1);
        check("clr_evt_cnt0", 32'(cnt_c[2:0]), 32'd1);
        check("clr_evt_sticky0", 32'(sticky_c[0]), 32'h1);
        clr_c[0] = 1'b1;
        tick();
        clr_c[0] = 1'b0;
        check("clr_only_cnt0", 32'(cnt_c[2:0]), 32'd0);
        check("clr_only_sticky0", 32'(sticky_c[0]), 32'h0);

        // ---------------- Random, mixed modes (A vs model) ----------------
        rst_a = 1'b1;
        din_a = 4'h0;
        clr_a = 4'h0;
        tick();
        tick();
        rst_a = 1'b0;
        h0 = '0; h1 = '0; h2 = '0; h3 = '0;
        m_sticky = '0;
        for (int c = 0; c < 4; c++) m_cnt[c] = '0;
        for (int i = 0; i < 300; i++) begin
            din_a = 4'($urandom);
            if (i % 20 == 0) mode_a = 8'($urandom);
            clr_a = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            mode_now = mode_a;
            clr_now  = clr_a;
            tick();
            h3 = h2; h2 = h1; h1 = h0; h0 = din_a;
            for (int c = 0; c < 4; c++) begin
                case (mode_now[2*c +: 2])
                    2'b00:   begin m_evt[c] = h2[c];              m_hit[c] = 1'b0;     end
                    2'b01:   begin m_evt[c] = h2[c] & ~h3[c];     m_hit[c] = m_evt[c]; end
                    2'b10:   begin m_evt[c] = ~h2[c] & h3[c];     m_hit[c] = m_evt[c]; end
                    default: begin m_evt[c] = h2[c] ^ h3[c];      m_hit[c] = m_evt[c]; end
                endcase
                if (m_hit[c]) m_sticky[c] = 1'b1;
                else if (clr_now[c]) m_sticky[c] = 1'b0;
                if (clr_now[c]) m_cnt[c] = {7'b0, m_hit[c]};
                else if (m_hit[c] && m_cnt[c] != 8'hFF) m_cnt[c] = m_cnt[c] + 8'd1;
            end
            check("rand_evt", 32'(evt_a), 32'(m_evt));
            check("rand_sticky", 32'(sticky_a), 32'(m_sticky));
            check("rand_cnt", cnt_a, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
